// File: rtl/dct_zigzag_quantizer.sv
// Reads an 8x8 DCT block in zigzag order, quantizes by reciprocal multiply and streams it out.
// Optional DC prediction is enabled with the DC_DPCM_EN macro.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FETCH | issuing coefficient reads, at most two in flight or buffered
// S_DRAIN | all reads issued, waiting for the k=63 handshake
// S_DONE  | one-cycle done pulse; a new start is accepted here
module dct_zigzag_quantizer #(
  parameter int DATA_W  = 16,
  parameter int RECIP_W = 16,
  parameter int OUT_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              memRd,
  output logic [5:0]        memAddr,
  input  logic [DATA_W-1:0] memData,
  output logic [OUT_W-1:0]  outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              outLast,
  output logic              busy,
  output logic              done
);

  localparam int MAG_W = DATA_W + RECIP_W;
  localparam int RM_W  = MAG_W - 16;

  localparam logic [0:63][7:0] Q_LUM = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam logic [0:63][5:0] ZZ = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // recip[a] = round(65536 / Q[a]), folded at elaboration time
  function automatic logic [63:0][RECIP_W-1:0] gen_recip();
    logic [63:0][RECIP_W-1:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = RECIP_W'((32'd65536 + 32'(Q_LUM[i] >> 1)) / 32'(Q_LUM[i]));
    return r;
  endfunction

  localparam logic [63:0][RECIP_W-1:0] RECIP = gen_recip();

  localparam logic [RM_W-1:0] POS_LIM = RM_W'(2 ** (OUT_W - 1) - 1);
  localparam logic [RM_W-1:0] NEG_LIM = RM_W'(2 ** (OUT_W - 1));

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                  state;
  logic [5:0]              k;
  logic                    inflight;
  logic [5:0]              rd_addr_q;
  logic                    rd_last_q;
`ifdef DC_DPCM_EN
  logic                    rd_first_q;
`endif

  logic [1:0][OUT_W:0]     fifo_mem;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              fifo_count;
  logic                    push;
  logic                    pop;
  logic [1:0]              credits_used;

  logic [DATA_W-1:0]       abs_c;
  logic [MAG_W-1:0]        mag;
  logic [RM_W-1:0]         rmag;
  logic [OUT_W-1:0]        q_sat;
  logic [OUT_W-1:0]        word;

  assign push     = inflight;
  assign pop      = outValid & outReady;
  assign outValid = (fifo_count != 2'd0);
  assign outData  = fifo_mem[rd_ptr][OUT_W-1:0];
  assign outLast  = outValid & fifo_mem[rd_ptr][OUT_W];
  assign memAddr  = ZZ[k];

  // A word leaving the FIFO this cycle frees its slot, which keeps reads back-to-back.
  assign credits_used = fifo_count - {1'b0, pop} + {1'b0, inflight};
  assign memRd        = (state == S_FETCH) && (credits_used < 2'd2);

  assign abs_c = memData[DATA_W-1] ? (~memData) + DATA_W'(1) : memData;
  assign mag   = MAG_W'(abs_c) * MAG_W'(RECIP[rd_addr_q]);
  assign rmag  = RM_W'((mag + MAG_W'(32768)) >> 16);

  always_comb begin
    q_sat = '0;
    if (!memData[DATA_W-1])
      q_sat = (rmag > POS_LIM) ? OUT_W'(POS_LIM) : rmag[OUT_W-1:0];
    else if (rmag > NEG_LIM)
      q_sat = {1'b1, {(OUT_W-1){1'b0}}};
    else
      q_sat = (~rmag[OUT_W-1:0]) + OUT_W'(1);
  end

`ifdef DC_DPCM_EN
  logic [OUT_W-1:0] prev_dc;
  logic [OUT_W:0]   dc_diff;
  logic [OUT_W-1:0] dc_sat;

  assign dc_diff = {q_sat[OUT_W-1], q_sat} - {prev_dc[OUT_W-1], prev_dc};

  always_comb begin
    dc_sat = dc_diff[OUT_W-1:0];
    if (dc_diff[OUT_W] != dc_diff[OUT_W-1])
      dc_sat = dc_diff[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  assign word = rd_first_q ? dc_sat : q_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prev_dc <= '0;
    else if (push && rd_first_q)
      prev_dc <= q_sat;
  end
`else
  assign word = q_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inflight  <= 1'b0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
`ifdef DC_DPCM_EN
      rd_first_q <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      inflight <= memRd;
      if (memRd) begin
        rd_addr_q <= memAddr;
        rd_last_q <= (k == 6'd63);
`ifdef DC_DPCM_EN
        rd_first_q <= (k == 6'd0);
`endif
        k <= k + 6'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
            k     <= '0;
          end
        end
        S_FETCH: begin
          if (memRd && k == 6'd63)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && outLast) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
            k     <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem   <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {rd_last_q, word};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dct_zigzag_quantizer.sv
// Scoreboard bench for dct_zigzag_quantizer; honours DC_DPCM_EN when defined.
module tb_dct_zigzag_quantizer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        memRd;
  logic [5:0]  memAddr;
  logic [15:0] memData;
  logic [11:0] outData;
  logic        outValid;
  logic        outReady;
  logic        outLast;
  logic        busy;
  logic        done;

  dct_zigzag_quantizer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .memRd    (memRd),
    .memAddr  (memAddr),
    .memData  (memData),
    .outData  (outData),
    .outValid (outValid),
    .outReady (outReady),
    .outLast  (outLast),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] mem [64];
  always @(posedge clk) if (memRd) memData <= mem[memAddr];

  typedef struct {int data; int last;} exp_t;
  exp_t exp_q[$];

  int qtab[64] = '{16, 11, 10, 16, 24, 40, 51, 61,
                   12, 12, 14, 19, 26, 58, 60, 55,
                   14, 13, 16, 24, 40, 57, 69, 56,
                   14, 17, 22, 29, 51, 87, 80, 62,
                   18, 22, 37, 56, 68, 109, 103, 77,
                   24, 35, 55, 64, 81, 104, 113, 92,
                   49, 64, 78, 87, 103, 121, 120, 101,
                   72, 92, 95, 98, 112, 100, 103, 99};
  int zz[64];
  int t3_coef[5] = '{160, -24, 24, 32767, -32768};
  int t3_q[5]    = '{10, -2, 2, 2047, -2048};

  int n_checks = 0, n_pass = 0;
  int cyc = 0, exp_idx = 0, words_seen = 0, done_cnt = 0, last_hs_cyc = -100;
  int exp_prev = 0, hold_v = 0, hold_d = 0, hold_l = 0;
  int blk_words0 = 0, blk_done0 = 0, first_v = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sat12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int quant(input int coef, input int a);
    longint q, rc, m, r;
    q  = qtab[a];
    rc = (65536 + q / 2) / q;
    m  = longint'(coef < 0 ? -coef : coef) * rc;
    r  = (m + 32768) >> 16;
    return sat12(coef < 0 ? -int'(r) : int'(r));
  endfunction

  // zigzag walk along anti-diagonals, direction alternating
  task automatic build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
      else            for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
    end
  endtask

  // mode 0: model, 1: literal DC with model AC, 2: identity word = zz[k]
  task automatic push_block(input int mode, input int lit);
    for (int k = 0; k < 64; k++) begin
      int w, qdc;
      w = 0;
      if (k == 0) begin
        qdc = (mode == 2) ? zz[0] : (mode == 1) ? lit : quant(int'(mem[0]), 0);
`ifdef DC_DPCM_EN
        w = sat12(qdc - exp_prev);
        exp_prev = qdc;
`else
        w = qdc;
`endif
      end else begin
        w = (mode == 2) ? zz[k] : quant(int'(mem[zz[k]]), zz[k]);
      end
      exp_q.push_back('{data: w, last: int'(k == 63)});
    end
  endtask

  task automatic monitor();
    if (!rst_n) begin
      exp_idx = exp_q.size();
      hold_v = 0;
    end else begin
      if (done) begin
        check("done_after_last", cyc, last_hs_cyc + 1);
        done_cnt++;
      end
      if (outValid && outReady) begin
        if (exp_idx < exp_q.size()) begin
          check("data", int'($signed(outData)), exp_q[exp_idx].data);
          check("last", int'(outLast), exp_q[exp_idx].last);
          exp_idx++;
        end else begin
          check("extra_word", exp_q.size() - exp_idx, 1);
        end
        words_seen++;
        if (outLast) last_hs_cyc = cyc;
        hold_v = 0;
      end else if (outValid) begin
        if (hold_v != 0) begin
          check("hold_data", int'(outData), hold_d);
          check("hold_last", int'(outLast), hold_l);
        end
        hold_v = 1;
        hold_d = int'(outData);
        hold_l = int'(outLast);
      end else begin
        hold_v = 0;
      end
    end
  endtask

  task automatic step();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
  endtask

  task automatic begin_block(input int mode, input int lit);
    push_block(mode, lit);
    blk_words0 = words_seen;
    blk_done0  = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_block();
    for (int i = 0; i < 400 && done_cnt == blk_done0; i++) step();
    check("done_seen", int'(done_cnt != blk_done0), 1);
    repeat (3) step();
    check("words_64", words_seen - blk_words0, 64);
    check("one_done", done_cnt - blk_done0, 1);
    check("exp_drained", exp_q.size() - exp_idx, 0);
    check("idle_busy", int'(busy), 0);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 300 && words_seen < blk_words0 + n; i++) step();
    check("reach_word", int'(words_seen >= blk_words0 + n), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_memRd"}, int'(memRd), 0);
    check({tag, "_memAddr"}, int'(memAddr), 0);
    check({tag, "_outData"}, int'(outData), 0);
    check({tag, "_outValid"}, int'(outValid), 0);
    check({tag, "_outLast"}, int'(outLast), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++) mem[a] = 16'(int'($urandom_range(0, 8000)) - 4000);
  endtask

  initial begin
    build_zz();
    rst_n = 1'b0;
    start = 1'b0;
    outReady = 1'b0;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    @(negedge clk);
    repeat (2) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // identity data with latency and back-to-back throughput
    for (int a = 0; a < 64; a++) mem[a] = 16'(qtab[a] * a);
    outReady = 1'b1;
    begin_block(2, 0);
    check("lat_rd", int'(memRd), 1);
    check("lat_v0", int'(outValid), 0);
    step();
    check("lat_v1", int'(outValid), 0);
    step();
    check("lat_v2", int'(outValid), 1);
    first_v = cyc;
    finish_block();
    check("consecutive", last_hs_cyc - first_v, 63);

    // rounding and saturation on the DC coefficient
    for (int a = 0; a < 64; a++) mem[a] = '0;
    for (int i = 0; i < 5; i++) begin
      mem[0] = 16'(t3_coef[i]);
      begin_block(1, t3_q[i]);
      finish_block();
    end

    // consumer stall at k=5
    fill_random();
    begin_block(0, 0);
    wait_words(5);
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1) check("stall_rd", int'(memRd), 0);
      check("stall_valid", int'(outValid), 1);
    end
    outReady = 1'b1;
    finish_block();

    // start while busy is ignored
    fill_random();
    begin_block(0, 0);
    wait_words(30);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_ignored", int'(busy), 1);
    finish_block();

    // reset in the middle of a block
    fill_random();
    begin_block(0, 0);
    wait_words(20);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
`ifdef DC_DPCM_EN
    exp_prev = 0;
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // two blocks with DC 160 then 112, AC zero
    for (int a = 0; a < 64; a++) mem[a] = '0;
    mem[0] = 16'sd160;
    begin_block(1, 10);
    finish_block();
    mem[0] = 16'sd112;
    begin_block(1, 7);
    finish_block();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
